// File: rtl/debug_run_controller.sv
// Run-control sequencer for a pipelined datapath under debug: decodes UART command bytes,
// gates pipeline enable/reset and requests register dumps after steps, EOP and watchdog expiry.
module debug_run_controller #(
  parameter logic [7:0] CMD_CONT   = 8'h63,
  parameter logic [7:0] CMD_STEP   = 8'h73,
  parameter logic [7:0] CMD_NEXT   = 8'h6E,
  parameter logic [7:0] CMD_RESET  = 8'h72,
  parameter int         MAX_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dataAvailable,
  input  logic [7:0]  rxData,
  output logic        readFifoFlag,
  input  logic        endOfProgram,
  input  logic        dumpDone,
  output logic        dumpReq,
  output logic        pipeEnable,
  output logic        pipeReset,
  output logic [15:0] cycleCount,
  output logic        timeout,
  output logic        ledIdle,
  output logic        ledCont,
  output logic        ledStep,
  output logic        ledSend,
  output logic [2:0]  debug_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONT       = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_PULSE = 3'd3,
    DUMP_REQ   = 3'd4
  } state_t;

  localparam logic [15:0] MAX_C = 16'(MAX_CYCLES);

  state_t      state, state_n;
  logic        eop_seen, eop_seen_n, from_step, from_step_n;
  logic        rff_n, dreq_n, en_n, prst_n, timeout_n, accept;
  logic [15:0] cnt_n, cnt_inc;

  assign debug_state = state;

  // RX handshake: the FIFO is first-word fall-through, so rxData is valid whenever
  // dataAvailable is high. A byte is consumed at an edge where dataAvailable=1 and
  // readFifoFlag=0; readFifoFlag is then high for the following cycle only, and the
  // FIFO pops on that cycle. The flag can never be high on two consecutive cycles,
  // which gives the FIFO a cycle to present its next head byte.
  always_comb begin
    cnt_inc     = (pipeEnable && cycleCount != 16'hFFFF) ? cycleCount + 16'd1 : cycleCount;
    accept      = (state == IDLE || state == STEP_WAIT) && dataAvailable && !readFifoFlag;
    state_n     = state;
    eop_seen_n  = eop_seen;
    from_step_n = from_step;
    rff_n       = accept;
    dreq_n      = 1'b0;
    en_n        = 1'b0;
    prst_n      = 1'b0;
    timeout_n   = timeout;
    cnt_n       = cnt_inc;
    case (state)
      IDLE, STEP_WAIT: begin
        if (accept) begin
          if (rxData == CMD_CONT) begin
            state_n = CONT;
            en_n    = 1'b1;
            // Continuing out of step mode keeps the running cycle count.
            if (state == IDLE) begin
              cnt_n      = 16'd0;
              timeout_n  = 1'b0;
              eop_seen_n = 1'b0;
            end
          end else if (rxData == CMD_STEP && state == IDLE) begin
            state_n    = STEP_WAIT;
            cnt_n      = 16'd0;
            timeout_n  = 1'b0;
            eop_seen_n = 1'b0;
          end else if (rxData == CMD_NEXT && state == STEP_WAIT) begin
            state_n = STEP_PULSE;
            en_n    = 1'b1;
          end else if (rxData == CMD_RESET) begin
            state_n   = IDLE;
            prst_n    = 1'b1;
            cnt_n     = 16'd0;
            timeout_n = 1'b0;
          end
        end
      end
      CONT: begin
        en_n = 1'b1;
        if (endOfProgram) eop_seen_n = 1'b1;
        if (cnt_inc >= MAX_C) timeout_n = 1'b1;
        if (endOfProgram || cnt_inc >= MAX_C) begin
          state_n     = DUMP_REQ;
          en_n        = 1'b0;
          dreq_n      = 1'b1;
          from_step_n = 1'b0;
        end
      end
      STEP_PULSE: begin
        state_n     = DUMP_REQ;
        dreq_n      = 1'b1;
        from_step_n = 1'b1;
        eop_seen_n  = eop_seen | endOfProgram;
      end
      DUMP_REQ: begin
        if (dumpDone) state_n = (from_step && !eop_seen) ? STEP_WAIT : IDLE;
        else          dreq_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      eop_seen     <= 1'b0;
      from_step    <= 1'b0;
      readFifoFlag <= 1'b0;
      dumpReq      <= 1'b0;
      pipeEnable   <= 1'b0;
      pipeReset    <= 1'b0;
      cycleCount   <= 16'd0;
      timeout      <= 1'b0;
      ledIdle      <= 1'b1;
      ledCont      <= 1'b0;
      ledStep      <= 1'b0;
      ledSend      <= 1'b0;
    end else begin
      state        <= state_n;
      eop_seen     <= eop_seen_n;
      from_step    <= from_step_n;
      readFifoFlag <= rff_n;
      dumpReq      <= dreq_n;
      pipeEnable   <= en_n;
      pipeReset    <= prst_n;
      cycleCount   <= cnt_n;
      timeout      <= timeout_n;
      ledIdle      <= (state_n == IDLE);
      ledCont      <= (state_n == CONT);
      ledStep      <= (state_n == STEP_WAIT) || (state_n == STEP_PULSE);
      ledSend      <= (state_n == DUMP_REQ);
    end
  end

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed bench for debug_run_controller: a first-word fall-through RX FIFO model feeds
// command bytes, and each scenario task checks pipeline/dump behaviour against hand values.
module tb_debug_run_controller;

  localparam int         MAX    = 24;
  localparam logic [7:0] C_CONT = 8'h63;
  localparam logic [7:0] C_STEP = 8'h73;
  localparam logic [7:0] C_NEXT = 8'h6E;
  localparam logic [7:0] C_RST  = 8'h72;

  logic        clock = 1'b0;
  logic        reset, dataAvailable, endOfProgram, dumpDone;
  logic [7:0]  rxData;
  logic        readFifoFlag, dumpReq, pipeEnable, pipeReset, timeout;
  logic        ledIdle, ledCont, ledStep, ledSend;
  logic [15:0] cycleCount;
  logic [2:0]  debug_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int   pops = 0, rff_adj = 0, en_cycles = 0, en_pulses = 0, en_long = 0;
  int   rst_pulses = 0, dreq_cycles = 0;
  logic rff_q = 1'b0, en_q = 1'b0;

  always #5 clock = ~clock;

  debug_run_controller #(.MAX_CYCLES(MAX)) dut (
    .clock(clock), .reset(reset), .dataAvailable(dataAvailable), .rxData(rxData),
    .readFifoFlag(readFifoFlag), .endOfProgram(endOfProgram), .dumpDone(dumpDone),
    .dumpReq(dumpReq), .pipeEnable(pipeEnable), .pipeReset(pipeReset),
    .cycleCount(cycleCount), .timeout(timeout), .ledIdle(ledIdle), .ledCont(ledCont),
    .ledStep(ledStep), .ledSend(ledSend), .debug_state(debug_state)
  );

  // One clock edge; outputs are sampled 1 ns after it and the FIFO model pops on a strobe.
  task tick();
    @(posedge clock);
    #1;
    if (rff_q && rx_q.size() > 0) void'(rx_q.pop_front());
    if (readFifoFlag) begin
      if (rff_q) rff_adj++;
      else       pops++;
    end
    rff_q = readFifoFlag;
    if (pipeEnable) en_cycles++;
    if (pipeEnable && !en_q) en_pulses++;
    if (pipeEnable && en_q) en_long++;
    en_q = pipeEnable;
    if (pipeReset) rst_pulses++;
    if (dumpReq) dreq_cycles++;
    dataAvailable = (rx_q.size() != 0);
    rxData        = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task push(input logic [7:0] b);
    rx_q.push_back(b);
    dataAvailable = 1'b1;
    rxData        = rx_q[0];
  endtask

  task test_reset();
    reset = 1'b1; dataAvailable = 1'b0; rxData = 8'h00; endOfProgram = 1'b0; dumpDone = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++; if ({readFifoFlag, dumpReq, pipeEnable, pipeReset, timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 00000", {readFifoFlag, dumpReq, pipeEnable, pipeReset, timeout}); end
    checks++; if (cycleCount !== 16'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", cycleCount); end
    checks++; if ({ledIdle, ledCont, ledStep, ledSend} !== 4'b1000) begin
      errors++; $display("FAIL reset_leds got %b want 1000", {ledIdle, ledCont, ledStep, ledSend}); end
    checks++; if (pops !== 0) begin
      errors++; $display("FAIL reset_no_pop got %0d want 0", pops); end
  endtask

  task test_cont_eop();
    int p0, e0, d0, n;
    p0 = pops; e0 = en_cycles; d0 = dreq_cycles; n = 0;
    push(C_CONT);
    while (!pipeEnable && n < 10) begin tick(); n++; end
    checks++; if ({pipeEnable, ledCont, ledIdle} !== 3'b110) begin
      errors++; $display("FAIL cont_start got %b want 110", {pipeEnable, ledCont, ledIdle}); end
    while (en_cycles - e0 < 20 && n < 60) begin tick(); n++; end
    endOfProgram = 1'b1;
    tick();
    endOfProgram = 1'b0;
    checks++; if ({pipeEnable, dumpReq, ledSend} !== 3'b011) begin
      errors++; $display("FAIL cont_eop_dump got %b want 011", {pipeEnable, dumpReq, ledSend}); end
    checks++; if (cycleCount !== 16'd20) begin
      errors++; $display("FAIL cont_count got %0d want 20", cycleCount); end
    repeat (4) tick();
    dumpDone = 1'b1;
    tick();
    dumpDone = 1'b0;
    checks++; if (dreq_cycles - d0 !== 5) begin
      errors++; $display("FAIL cont_dumpreq_len got %0d want 5", dreq_cycles - d0); end
    checks++; if ({ledIdle, dumpReq, timeout} !== 3'b100) begin
      errors++; $display("FAIL cont_back_idle got %b want 100", {ledIdle, dumpReq, timeout}); end
    checks++; if (en_cycles - e0 !== 20 || pops - p0 !== 1) begin
      errors++; $display("FAIL cont_en_pops got %0d/%0d want 20/1", en_cycles - e0, pops - p0); end
  endtask

  task test_step();
    int p0, e0, u0, l0;
    p0 = pops; e0 = en_cycles; u0 = en_pulses; l0 = en_long;
    push(C_STEP); push(C_NEXT); push(C_NEXT);
    repeat (30) begin
      tick();
      if (dumpDone) dumpDone = 1'b0;
      else if (dumpReq) dumpDone = 1'b1;
    end
    dumpDone = 1'b0;
    checks++; if (en_cycles - e0 !== 2 || en_pulses - u0 !== 2 || en_long - l0 !== 0) begin
      errors++; $display("FAIL step_pulses got %0d/%0d/%0d want 2/2/0", en_cycles - e0, en_pulses - u0, en_long - l0); end
    checks++; if (cycleCount !== 16'd2) begin
      errors++; $display("FAIL step_count got %0d want 2", cycleCount); end
    checks++; if ({ledStep, pipeEnable, dumpReq} !== 3'b100 || debug_state !== 3'd2) begin
      errors++; $display("FAIL step_wait got %b state %0d want 100 state 2", {ledStep, pipeEnable, dumpReq}, debug_state); end
    checks++; if (pops - p0 !== 3 || rff_adj !== 0) begin
      errors++; $display("FAIL step_pops got %0d adj %0d want 3 adj 0", pops - p0, rff_adj); end
  endtask

  task test_step_to_cont();
    int e0, n;
    e0 = en_cycles; n = 0;
    push(C_CONT);
    while (!dumpReq && n < 80) begin tick(); n++; end
    checks++; if (en_cycles - e0 !== MAX - 2) begin
      errors++; $display("FAIL stepcont_en got %0d want %0d", en_cycles - e0, MAX - 2); end
    checks++; if (cycleCount !== 16'(MAX) || {timeout, pipeEnable} !== 2'b10) begin
      errors++; $display("FAIL stepcont_wdog got %0d %b want %0d 10", cycleCount, {timeout, pipeEnable}, MAX); end
    dumpDone = 1'b1;
    tick();
    dumpDone = 1'b0;
    checks++; if ({ledIdle, ledStep} !== 2'b10) begin
      errors++; $display("FAIL stepcont_exit got %b want 10", {ledIdle, ledStep}); end
  endtask

  task test_watchdog();
    int e0, n;
    e0 = en_cycles; n = 0;
    push(C_CONT);
    while (!pipeEnable && n < 10) begin tick(); n++; end
    checks++; if (timeout !== 1'b0 || cycleCount !== 16'd0) begin
      errors++; $display("FAIL wdog_clear got %b %0d want 0 0", timeout, cycleCount); end
    while (!dumpReq && n < 80) begin tick(); n++; end
    checks++; if (en_cycles - e0 !== MAX || cycleCount !== 16'(MAX)) begin
      errors++; $display("FAIL wdog_len got %0d %0d want %0d", en_cycles - e0, cycleCount, MAX); end
    checks++; if ({timeout, dumpReq, pipeEnable, ledSend} !== 4'b1101) begin
      errors++; $display("FAIL wdog_flags got %b want 1101", {timeout, dumpReq, pipeEnable, ledSend}); end
    dumpDone = 1'b1;
    tick();
    dumpDone = 1'b0;
  endtask

  task test_back_to_back();
    int p0, r0;
    p0 = pops; r0 = rst_pulses;
    push(8'h78); push(C_RST);
    repeat (8) tick();
    checks++; if (pops - p0 !== 2 || rff_adj !== 0) begin
      errors++; $display("FAIL b2b_pops got %0d adj %0d want 2 adj 0", pops - p0, rff_adj); end
    checks++; if (rst_pulses - r0 !== 1) begin
      errors++; $display("FAIL b2b_pipereset got %0d want 1", rst_pulses - r0); end
    checks++; if (cycleCount !== 16'd0 || timeout !== 1'b0 || ledIdle !== 1'b1) begin
      errors++; $display("FAIL b2b_clear got %0d %b %b want 0 0 1", cycleCount, timeout, ledIdle); end
  endtask

  task test_eop_step();
    int e0, u0;
    e0 = en_cycles; u0 = en_pulses;
    endOfProgram = 1'b1;
    push(C_STEP); push(C_NEXT);
    repeat (20) begin
      tick();
      if (dumpDone) dumpDone = 1'b0;
      else if (dumpReq) dumpDone = 1'b1;
    end
    dumpDone = 1'b0; endOfProgram = 1'b0;
    checks++; if (en_cycles - e0 !== 1 || en_pulses - u0 !== 1 || cycleCount !== 16'd1) begin
      errors++; $display("FAIL eopstep_pulse got %0d/%0d/%0d want 1/1/1", en_cycles - e0, en_pulses - u0, cycleCount); end
    checks++; if ({ledIdle, ledStep} !== 2'b10) begin
      errors++; $display("FAIL eopstep_exit got %b want 10", {ledIdle, ledStep}); end
  endtask

  task test_reset_mid();
    int p0, n;
    p0 = pops; n = 0;
    push(C_STEP); push(C_NEXT);
    while (!dumpReq && n < 20) begin tick(); n++; end
    checks++; if (dumpReq !== 1'b1 || ledStep !== 1'b0) begin
      errors++; $display("FAIL rmid_reach_dump got %b want 1", dumpReq); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({dumpReq, pipeEnable, readFifoFlag, ledIdle, ledSend} !== 5'b00010 || debug_state !== 3'd0) begin
      errors++; $display("FAIL rmid_async got %b state %0d want 00010 state 0", {dumpReq, pipeEnable, readFifoFlag, ledIdle, ledSend}, debug_state); end
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (pops - p0 !== 2 || rff_adj !== 0 || ledIdle !== 1'b1) begin
      errors++; $display("FAIL rmid_after got %0d adj %0d idle %b want 2 0 1", pops - p0, rff_adj, ledIdle); end
  endtask

  initial begin
    test_reset();
    test_cont_eop();
    test_step();
    test_step_to_cont();
    test_watchdog();
    test_back_to_back();
    test_eop_step();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
